arb4_encoder_ctrl: RTL and testbench
====================================

Name: arb4_encoder_ctrl

Overview:
- Round-robin arbiter and sequencer for a shared 4-input encoder resource.
- Four requesters raise `req` lines. The block grants one owner at a time.
- It drives a one-hot `grant` and the 2-bit encoded owner index `grant_idx`, which is the encoder output seen by downstream logic.
- `en` gates all arbitration, matching the encoder's enable semantics.

Parameters:
- MAX_HOLD, 8, maximum consecutive grant cycles per owner. Used only when ARB_TIMEOUT_EN is defined. Legal range 2..255.
- CNT_W, 8, width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  arbitration enable. Low forces release and blocks new grants.
- req  input  4  request lines. req[k] is held high by requester k while it needs the resource.
- grant  output  4  one-hot grant, registered. All zero when no owner.
- grant_idx  output  2  binary index of the current owner, registered. Holds the last owner's value when grant_valid=0.
- grant_valid  output  1  high while grant is non-zero.
- timeout  output  1  one-cycle pulse on a forced release (ARB_TIMEOUT_EN only, else tied 0).

Behaviour:
- Reset (async, immediate): grant=4'b0000, grant_idx=2'b00, grant_valid=0, timeout=0, ptr=2'd0, hold_cnt=0, state=IDLE.
- Reset asserted mid-grant clears all outputs without waiting for a clock edge.
- State IDLE:
  - If en=1 and |req: select the first k with req[k]=1, searching ptr, ptr+1, ... mod 4.
  - On the next edge: grant=1<<k, grant_idx=k, grant_valid=1, hold_cnt=0, state=GRANT.
  - Latency from req to grant: 1 clock.
  - Otherwise remain in IDLE with outputs cleared.
- State GRANT, owner o:
  - Hold: if en=1 and req[o]=1 (and no timeout), keep the grant and increment hold_cnt.
  - Release: if req[o]=0, on the next edge clear grant and grant_valid, set ptr=o+1 mod 4, and go to IDLE.
  - Disable: if en=0, clear grant on the next edge, set ptr=o+1 mod 4, and go to IDLE. Takes priority over release and timeout; timeout stays 0.
- Every release costs exactly one idle cycle (grant_valid=0) before the next grant. This cycle is mandatory even when other requests are pending.
- Changes to req[j] for j≠o during GRANT are ignored until the owner releases.
- ptr wrap-around: owner 3 releases -> ptr=0.
- Starvation-free: with all four requesting continuously, grants rotate 0,1,2,3,0,...
- All outputs come directly from flops. There are no combinational paths from req or en to the outputs.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - In GRANT with en=1, when hold_cnt reaches MAX_HOLD-1 and req[o] is still high, force a release on the next edge.
  - The forced release behaves exactly like a normal release (grant cleared, ptr=o+1 mod 4, go to IDLE).
  - timeout=1 for that one cycle, coincident with grant_valid dropping.
  - An owner therefore holds for at most MAX_HOLD cycles.
- Not defined:
  - No hold counter logic is synthesized and timeout is tied to 0.
  - The owner may hold indefinitely while req[o]=1 and en=1.

Test Plan:
1. Reset, then en=1, req=4'b0100 -> one clock later grant=4'b0100, grant_idx=2'd2, grant_valid=1. Drop req -> next edge grant=0, internal ptr=3.
2. req=4'b1111 held, en=1, each owner drops its req after 2 grant cycles and re-raises it during the idle cycle -> grant_idx sequence 0,1,2,3,0. Each grant is separated by exactly one grant_valid=0 cycle.
3. Owner 3 granted with req=4'b1001, then req[3] dropped -> ptr wraps to 0, next grant_idx=0 after one idle cycle.
4. Owner 1 granted, en driven low for 1 cycle while req=4'b0011 -> grant clears next edge, timeout=0. With en back high, next grant goes to idx 0 (ptr=2 search wraps to 0).
5. ARB_TIMEOUT_EN, MAX_HOLD=4, req=4'b0011 held -> grant 0 held exactly 4 cycles, timeout pulses for 1 cycle, idle 1 cycle, then grant_idx=1. Without the macro, grant 0 persists for more than 20 cycles and timeout stays 0.
6. Assert rst asynchronously (not aligned to clk) during grant -> grant, grant_valid and grant_idx read 0 before the next clk edge. After release with req=4'b1000, first grant is idx 3 (search from ptr=0).

Source files
------------

// File: rtl/arb4_encoder_ctrl.sv
// rtl/arb4_encoder_ctrl.sv - round-robin arbiter/sequencer for a shared 4-input encoder
// Optional forced-release timeout is built when macro ARB_TIMEOUT_EN is defined.
module arb4_encoder_ctrl #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state, state_n;
  logic [1:0] ptr, ptr_n;
  logic [1:0] sel;
  logic [1:0] idx_n;
  logic [3:0] grant_n;
  logic       valid_n;
  logic       owner_req;
  logic       hold_expired;

  // Parameter sanity: hold counter must be able to reach MAX_HOLD-1.
  if (MAX_HOLD < 2 || MAX_HOLD > 255 || (64'd1 << CNT_W) <= 64'(MAX_HOLD)) begin : g_bad_params
  end

  assign owner_req = req[grant_idx];

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt, hold_cnt_n;
  logic             timeout_n;

  assign hold_expired = (hold_cnt == CNT_W'(MAX_HOLD - 1));
`else
  assign hold_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  // Round-robin pick: first requester at or after ptr (iterate backwards so the nearest wins).
  always_comb begin
    sel = ptr;
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr + 2'(i)]) sel = ptr + 2'(i);
    end
  end

  // Next-state and next-output decode; all outputs are registered below.
  always_comb begin
    state_n = state;
    grant_n = grant;
    idx_n   = grant_idx;
    valid_n = grant_valid;
    ptr_n   = ptr;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_n = hold_cnt;
    timeout_n  = 1'b0;
`endif
    case (state)
      IDLE: begin
        grant_n = 4'b0000;
        valid_n = 1'b0;
        if (en && (|req)) begin
          grant_n = 4'(1) << sel;
          idx_n   = sel;
          valid_n = 1'b1;
          state_n = GRANT;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_n = '0;
`endif
        end
      end
      GRANT: begin
        // Disable wins over release and timeout; any of them costs one idle cycle.
        if (!en || !owner_req || hold_expired) begin
          grant_n = 4'b0000;
          valid_n = 1'b0;
          ptr_n   = grant_idx + 2'd1;
          state_n = IDLE;
`ifdef ARB_TIMEOUT_EN
          timeout_n = en && owner_req && hold_expired;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
          hold_cnt_n = hold_cnt + 1'b1;
`endif
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = 4'b0000;
        valid_n = 1'b0;
      end
    endcase
  end

  // State, pointer and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= 2'd0;
      grant       <= 4'b0000;
      grant_idx   <= 2'd0;
      grant_valid <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      grant       <= grant_n;
      grant_idx   <= idx_n;
      grant_valid <= valid_n;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Hold counter and the one-cycle timeout pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      hold_cnt <= hold_cnt_n;
      timeout  <= timeout_n;
    end
  end
`endif

endmodule

// File: tb/tb_arb4_encoder_ctrl.sv
// tb/tb_arb4_encoder_ctrl.sv - self-checking bench for arb4_encoder_ctrl (ARB_TIMEOUT_EN aware)
module tb_arb4_encoder_ctrl;

  localparam int MH = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int n_vec = 0;
  int n_bad = 0;

  // reference model: owner (-1 = none), next search start, last owner, cycles held so far
  int m_owner = -1;
  int m_ptr   = 0;
  int m_last  = 0;
  int m_held  = 0;
  bit m_to    = 1'b0;

  arb4_encoder_ctrl #(.MAX_HOLD(MH), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .req         (req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_last = 0; m_held = 0; m_to = 1'b0;
  endtask

  // one clock edge of the arbitration rules, using the inputs present at that edge
  task automatic model_step(input bit e, input logic [3:0] r);
    bit expired;
    m_to = 1'b0;
    if (m_owner < 0) begin
      if (e && r != 4'b0000) begin
        for (int k = 3; k >= 0; k--) begin
          if (r[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
        end
        m_last = m_owner;
        m_held = 1;
      end
    end else begin
      expired = TO && (m_held >= MH);
      if (!e || !r[m_owner] || expired) begin
        m_to    = e && r[m_owner] && expired;
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] eg;
    eg = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
    chk({tag, ".grant"}, {4'h0, grant}, eg);
    chk({tag, ".idx"}, {6'h0, grant_idx}, 8'(m_last));
    chk({tag, ".valid"}, {7'h0, grant_valid}, (m_owner < 0) ? 8'h00 : 8'h01);
    chk({tag, ".timeout"}, {7'h0, timeout}, {7'h0, m_to});
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step(en, req);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    model_reset();
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int seq[$];
    int hold0;
    int pulses;
    bit seen1;

    // 1: single request, then release; ptr moves to 3
    do_reset();
    en = 1'b1; req = 4'b0100;
    cycle("t1_grant");
    chk("t1_idx2", {6'h0, grant_idx}, 8'd2);
    chk("t1_onehot", {4'h0, grant}, 8'h04);
    req = 4'b0000;
    cycle("t1_release");
    chk("t1_valid0", {7'h0, grant_valid}, 8'h00);
    req = 4'b1111;
    cycle("t1_ptr3");
    chk("t1_ptr3_idx", {6'h0, grant_idx}, 8'd3);

    // 2: all requesting, each owner yields after 2 grant cycles
    do_reset();
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      cycle("t2_grant");
      seq.push_back(int'(grant_idx));
      cycle("t2_hold");
      req[grant_idx] = 1'b0;
      cycle("t2_idle");
      chk("t2_gap", {7'h0, grant_valid}, 8'h00);
      req = 4'b1111;
    end
    for (int n = 0; n < 5; n++) chk("t2_rotation", 8'(seq[n]), 8'(n % 4));

    // 3: owner 3 releases, ptr wraps to 0
    do_reset();
    req = 4'b1000;
    cycle("t3_grant3");
    req = 4'b1001;
    cycle("t3_hold");
    req = 4'b0001;
    cycle("t3_idle");
    cycle("t3_grant0");
    chk("t3_wrap_idx0", {6'h0, grant_idx}, 8'd0);

    // 4: disable while owner 1 holds
    do_reset();
    req = 4'b0010;
    cycle("t4_grant1");
    req = 4'b0011; en = 1'b0;
    cycle("t4_disable");
    chk("t4_no_timeout", {7'h0, timeout}, 8'h00);
    en = 1'b1;
    cycle("t4_regrant");
    chk("t4_idx0", {6'h0, grant_idx}, 8'd0);

    // 5: long hold with two requesters
    do_reset();
    req = 4'b0011;
    hold0 = 0; pulses = 0; seen1 = 1'b0;
    for (int n = 0; n < 30; n++) begin
      cycle("t5");
      if (grant_valid && grant_idx == 2'd0 && !seen1) hold0++;
      if (grant_valid && grant_idx == 2'd1) seen1 = 1'b1;
      if (timeout) pulses++;
    end
    if (TO) begin
      chk("t5_hold_len", 8'(hold0), 8'(MH));
      chk("t5_idx1_seen", {7'h0, seen1}, 8'h01);
      chk("t5_pulse_seen", {7'h0, (pulses > 0)}, 8'h01);
    end else begin
      chk("t5_hold_forever", {7'h0, (hold0 > 20)}, 8'h01);
      chk("t5_no_pulse", 8'(pulses), 8'h00);
    end

    // 6: asynchronous reset mid-grant
    req = 4'b0100;
    do_reset();
    cycle("t6_grant2");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("t6_async");
    #3 rst = 1'b0;
    req = 4'b1000;
    cycle("t6_after");
    chk("t6_idx3", {6'h0, grant_idx}, 8'd3);

    // random traffic against the model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
